// File: rtl/jk_pkg.sv
// Shared JK mode encoding and next-state rule used by every JK cell.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nxt;
    case ({j, k})
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = 1'bx;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flop; Q_BAR is the inverse of the one state bit, so it can never equal Q.
module jk_cell
  import jk_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_BAR
);

  logic state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= 1'b0;
    else     state <= jk_next(state, J, K);
  end

  assign Q     = state;
  assign Q_BAR = ~state;

endmodule

// File: rtl/jk_flip_flop.sv
// WIDTH independent JK flip-flops sharing one clock and one asynchronous reset.
module jk_flip_flop
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_BAR
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .CLK   (CLK),
      .RST   (RST),
      .J     (J[i]),
      .K     (K[i]),
      .Q     (Q[i]),
      .Q_BAR (Q_BAR[i])
    );
  end

endmodule

// File: tb/tb_jk_flip_flop.sv
// Checks a 4-bit JK register against a truth-table reference model plus literal expectations.
module tb_jk_flip_flop;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] J   = '0;
  logic [W-1:0] K   = '0;
  logic [W-1:0] Q;
  logic [W-1:0] Q_BAR;

  int checks = 0;
  int errors = 0;

  // Reference: next Q indexed by {J,K,Q} straight from the JK truth table.
  bit           next_tbl [8] = '{0, 1, 0, 0, 1, 1, 1, 0};
  logic [W-1:0] model_q = '0;

  jk_flip_flop #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .J     (J),
    .K     (K),
    .Q     (Q),
    .Q_BAR (Q_BAR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!RST)
      for (int i = 0; i < W; i++)
        model_q[i] = next_tbl[{J[i], K[i], model_q[i]}];
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, just after each rising edge.
  always @(posedge CLK) begin
    #1;
    check("model_q", Q, model_q);
    check("q_bar_inv", Q_BAR, ~Q);
  end

  task automatic tick(input logic [W-1:0] j, input logic [W-1:0] k);
    @(negedge CLK);
    J = j;
    K = k;
    @(posedge CLK);
    #2;
  endtask

  task automatic async_reset_pulse();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    model_q = '0;
    #1;
    check("async_rst_q", Q, '0);
    check("async_rst_qbar", Q_BAR, '1);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at %0t: got timeout, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset_q", Q, '0);
    check("reset_qbar", Q_BAR, '1);
    // Edges while reset is held must be ignored.
    J = '1;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    check("reset_hold_q", Q, '0);
    @(negedge CLK);
    J = '0;
    RST = 1'b0;
    #1;
    check("deassert_q", Q, '0);

    tick('1, '0);             check("set", Q, 4'b1111); check("set_model", model_q, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick('0, '0);           check("hold", Q, 4'b1111); check("hold_qbar", Q_BAR, 4'b0000);
    end

    tick('1, '1);             check("toggle1", Q, 4'b0000);
    tick('1, '1);             check("toggle2", Q, 4'b1111);
    tick('1, '1);             check("toggle3", Q, 4'b0000);
    tick('1, '1);             check("toggle4", Q, 4'b1111);

    tick('0, '1);             check("kreset1", Q, 4'b0000);
    tick('0, '1);             check("kreset2", Q, 4'b0000);

    // J pulses only while CLK is low; nothing may be captured.
    @(negedge CLK);
    J = '0; K = '0;
    #1 J = '1;
    #2 J = '0;
    #1 check("no_level_path", Q, 4'b0000);
    @(posedge CLK);
    #2 check("no_sample_between", Q, 4'b0000);

    // Mixed per-bit modes: set, reset, toggle, hold.
    tick(4'b1010, 4'b0110);   check("mixed1", Q, 4'b1010); check("mixed1_model", model_q, 4'b1010);
    check("mixed1_qbar", Q_BAR, 4'b0101);
    tick(4'b1111, 4'b1111);   check("mixed2", Q, 4'b0101); check("mixed2_qbar", Q_BAR, 4'b1010);

    tick('1, '0);             check("pre_pulse", Q, 4'b1111);
    async_reset_pulse();
    check("post_pulse", Q, 4'b0000);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) async_reset_pulse();
      else tick(W'($urandom), W'($urandom));
    end

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
